fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage control, instruction-ROM and IF/ID pipeline signals.
// The master side is the fetch stage; the slave side is the surrounding pipeline and ROM.
interface fetch_stage_if #(
  parameter int N = 64
);
  logic         stall;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic [5:0]   imem_addr;
  logic [31:0]  imem_q;
  logic [N-1:0] pc_F;
  logic [31:0]  instr_D;
  logic [N-1:0] pc_D;
  logic         valid_D;
  logic [15:0]  fetch_cnt;

  modport master (
    input  stall, branch_taken, branch_target, imem_q,
    output imem_addr, pc_F, instr_D, pc_D, valid_D, fetch_cnt
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_q,
    input  imem_addr, pc_F, instr_D, pc_D, valid_D, fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall handling and the IF/ID pipeline register.
// A BOOT state after reset delays the first fetch by one edge so that word 0 is fetched first.
module fetch_stage #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_r;
  logic [N-1:0] pc_r;
  logic [31:0]  instr_r;
  logic [N-1:0] pc_d_r;
  logic         valid_r;
  logic [15:0]  cnt_r;

  // ROM address comes straight from the PC register, so stall/branch never reach it combinationally
  assign bus.imem_addr = pc_r[7:2];
  assign bus.pc_F      = pc_r;
  assign bus.instr_D   = instr_r;
  assign bus.pc_D      = pc_d_r;
  assign bus.valid_D   = valid_r;
  assign bus.fetch_cnt = cnt_r;

  // Control FSM, PC update and IF/ID register; a redirect outranks a stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BOOT;
      pc_r    <= {N{1'b0}};
      instr_r <= 32'h0000_0000;
      pc_d_r  <= {N{1'b0}};
      valid_r <= 1'b0;
      cnt_r   <= 16'h0000;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
        end
        RUN: begin
          if (bus.branch_taken) begin
            pc_r    <= {bus.branch_target[N-1:2], 2'b00};
            instr_r <= 32'h0000_0000;
            pc_d_r  <= {N{1'b0}};
            valid_r <= 1'b0;
          end else if (!bus.stall) begin
            pc_r    <= pc_r + N'(3'd4);
            instr_r <= bus.imem_q;
            pc_d_r  <= pc_r;
            valid_r <= 1'b1;
            cnt_r   <= cnt_r + 16'd1;
          end else begin
            pc_r    <= pc_r;
            instr_r <= instr_r;
            pc_d_r  <= pc_d_r;
            valid_r <= valid_r;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage, checked against a behavioural PC/pipeline model.
module tb_fetch_stage;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if #(.N(N)) bus ();
  fetch_stage #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [64];
  assign bus.imem_q = rom[bus.imem_addr];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit           m_boot;
  logic [N-1:0] m_pc;
  logic [N-1:0] m_pcd;
  logic [31:0]  m_instr;
  bit           m_valid;
  int unsigned  m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pc_F"},      64'(bus.pc_F),      64'(m_pc));
    chk({tag, ":imem_addr"}, 64'(bus.imem_addr), (64'(m_pc) / 64'd4) % 64'd64);
    chk({tag, ":instr_D"},   64'(bus.instr_D),   64'(m_instr));
    chk({tag, ":pc_D"},      64'(bus.pc_D),      64'(m_pcd));
    chk({tag, ":valid_D"},   64'(bus.valid_D),   64'(m_valid));
    chk({tag, ":fetch_cnt"}, 64'(bus.fetch_cnt), 64'(m_cnt % 32'd65536));
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = '0;
    m_pcd   = '0;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // Apply inputs, take one rising edge, advance the model and compare every output
  task automatic cycle(input bit st, input bit br, input logic [N-1:0] tgt, input string tag);
    int idx;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    idx = int'((m_pc / 4) % 64);
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (br) begin
      m_pc    = tgt - (tgt % 4);
      m_instr = 32'h0;
      m_pcd   = '0;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = rom[idx];
      m_pcd   = m_pc;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 1;
      m_pc    = m_pc + 4;
    end
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'hA000_0000;
    rom[1] = 32'hA000_0001;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    reset = 1'b1;
    model_reset();
    #2 check_all("reset_hold");
    @(posedge clk);
    #1 check_all("reset_edge");
    #3 reset = 1'b0;

    // Boot sequence and first two fetches
    cycle(1'b0, 1'b0, '0, "boot");
    chk("boot_pc", 64'(bus.pc_F), 64'h0);
    cycle(1'b0, 1'b0, '0, "fetch0");
    chk("fetch0_instr", 64'(bus.instr_D), 64'hA000_0000);
    chk("fetch0_pc",    64'(bus.pc_F),    64'h4);
    cycle(1'b0, 1'b0, '0, "fetch1");
    chk("fetch1_instr", 64'(bus.instr_D), 64'hA000_0001);
    chk("fetch1_cnt",   64'(bus.fetch_cnt), 64'd2);

    // Stall hold at pc 8, then release
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, "stall");
    chk("stall_pc", 64'(bus.pc_F), 64'h8);
    cycle(1'b0, 1'b0, '0, "stall_rel");
    chk("stall_rel_pc", 64'(bus.pc_F), 64'hC);

    // Misaligned redirect together with stall
    cycle(1'b1, 1'b1, 64'h2E, "br_mis");
    chk("br_mis_addr", 64'(bus.imem_addr), 64'd11);
    cycle(1'b0, 1'b0, '0, "br_after");
    chk("br_after_pcd", 64'(bus.pc_D), 64'h2C);

    // Inputs toggled between edges must not disturb the ROM address
    bus.branch_taken  = 1'b1;
    bus.stall         = 1'b1;
    bus.branch_target = 64'h80;
    #1 chk("no_comb_path", 64'(bus.imem_addr), (64'(m_pc) / 64'd4) % 64'd64);

    // ROM index wrap 63 -> 0
    cycle(1'b0, 1'b1, 64'hFC, "to_fc");
    cycle(1'b0, 1'b0, '0, "wrap_rom");
    chk("wrap_rom_pc",   64'(bus.pc_F),      64'h100);
    chk("wrap_rom_addr", 64'(bus.imem_addr), 64'd0);

    // Back-to-back redirects
    cycle(1'b0, 1'b1, 64'h40, "br_a");
    cycle(1'b1, 1'b1, 64'h81, "br_b");
    cycle(1'b0, 1'b0, '0, "br_c");

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      logic [N-1:0] t;
      t = {$urandom, $urandom};
      cycle(($urandom % 4) == 0, ($urandom % 6) == 0, t, "rand");
    end

    // PC wrap modulo 2^N
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "to_top");
    cycle(1'b0, 1'b0, '0, "pc_wrap");
    chk("pc_wrap_pc",   64'(bus.pc_F),      64'h0);
    chk("pc_wrap_addr", 64'(bus.imem_addr), 64'd0);

    // Asynchronous reset mid-operation
    do_reset("sync_rst");
    cycle(1'b0, 1'b0, '0, "boot2");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, "run5");
    chk("run5_cnt",   64'(bus.fetch_cnt), 64'd5);
    chk("run5_valid", 64'(bus.valid_D),   64'd1);
    bus.stall = 1'b1;
    #3 reset = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst_cnt", 64'(bus.fetch_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 1'b0, '0, "boot3");
    cycle(1'b0, 1'b0, '0, "first_after");
    chk("first_after_instr", 64'(bus.instr_D), 64'hA000_0000);
    chk("first_after_pcd",   64'(bus.pc_D),    64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
